// File: rtl/ram16x8_pkg.sv
// Shared constants and response payload for the 16x8 memory responder.
// Imported by the storage block and the response pipeline.
package ram16x8_pkg;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } ram_rsp_t;

endpackage

// File: rtl/ram16x8_store.sv
// Data array, written-location bitmap and distinct-write counter.
// Presents a write-first combinational lookup for the read address.
module ram16x8_store
  import ram16x8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output ram_rsp_t      rsp,
  output logic [AW:0]   wcount
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] wr_q;
  logic [DEPTH-1:0] wr_d;
  logic [AW:0]      wcount_q;
  logic [AW:0]      wcount_d;

  always_comb begin
    mem_d    = mem_q;
    wr_d     = clr ? '0 : wr_q;
    wcount_d = clr ? '0 : wcount_q;
    if (we) begin
      mem_d[waddr] = din;
      wr_d[waddr]  = 1'b1;
      // clr wipes the bitmap, so the write always counts then
      if (clr || !wr_q[waddr]) begin
        wcount_d = wcount_d + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    rsp.data = '0;
    rsp.err  = 1'b1;
    if (we && (waddr == raddr)) begin
      rsp.data = din;
      rsp.err  = 1'b0;
    end else if (!clr && wr_q[raddr]) begin
      rsp.data = mem_q[raddr];
      rsp.err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      wcount_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      wcount_q <= wcount_d;
    end
  end

  assign wcount = wcount_q;

endmodule

// File: rtl/sync_ram_resp16x8.sv
// 16x8 memory responder with read-valid, unwritten-read error flag and
// an optional second output register stage.
module sync_ram_resp16x8 #(
  parameter int DW      = ram16x8_pkg::DW,
  parameter int AW      = ram16x8_pkg::AW,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout,
  output logic          rvalid,
  output logic          rerr,
  output logic [AW:0]   wcount
);
  import ram16x8_pkg::*;

  ram_rsp_t rsp;
  ram_rsp_t s1_q;
  ram_rsp_t s1_d;
  ram_rsp_t s2_q;
  ram_rsp_t s2_d;
  logic     v1_q;
  logic     v1_d;
  logic     v2_q;
  logic     v2_d;

  ram16x8_store u_store (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (clr),
    .we     (we),
    .waddr  (waddr),
    .din    (din),
    .raddr  (raddr),
    .rsp    (rsp),
    .wcount (wcount)
  );

  // data holds between reads; err only reports on a valid beat
  always_comb begin
    v1_d      = re;
    s1_d.data = re ? rsp.data : s1_q.data;
    s1_d.err  = re & rsp.err;
    v2_d      = v1_q;
    s2_d.data = v1_q ? s1_q.data : s2_q.data;
    s2_d.err  = v1_q & s1_q.err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      s1_q <= '0;
      v2_q <= 1'b0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      s1_q <= s1_d;
      v2_q <= v2_d;
      s2_q <= s2_d;
    end
  end

  always_comb begin
    if (OUT_REG != 0) begin
      dout   = s2_q.data;
      rvalid = v2_q;
      rerr   = s2_q.err;
    end else begin
      dout   = s1_q.data;
      rvalid = v1_q;
      rerr   = s1_q.err;
    end
  end

endmodule

// File: tb/tb_sync_ram_resp16x8.sv
// Bench for sync_ram_resp16x8: latency-1 and latency-2 instances share
// stimulus and are checked against a behavioural memory model.
module tb_sync_ram_resp16x8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [3:0] waddr = '0;
  logic [3:0] raddr = '0;
  logic [7:0] din = '0;

  logic [7:0] dout0, dout1;
  logic       rv0, rv1, rerr0, rerr1;
  logic [4:0] wc0, wc1;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m_mem [16];
  bit         m_bm [16];
  int         m_wc;
  bit         e_v0, e_e0, e_v1, e_e1, p_v, p_e;
  logic [7:0] e_d0, e_d1, p_d;

  always #5 clk = ~clk;

  sync_ram_resp16x8 #(.OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr),
    .din(din), .re(re), .raddr(raddr), .dout(dout0),
    .rvalid(rv0), .rerr(rerr0), .wcount(wc0)
  );

  sync_ram_resp16x8 #(.OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr),
    .din(din), .re(re), .raddr(raddr), .dout(dout1),
    .rvalid(rv1), .rerr(rerr1), .wcount(wc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":dout0"}, dout0, e_d0);
    chk({tag, ":rv0"}, rv0, e_v0);
    chk({tag, ":rerr0"}, rerr0, e_e0);
    chk({tag, ":wc0"}, wc0, m_wc);
    chk({tag, ":dout1"}, dout1, e_d1);
    chk({tag, ":rv1"}, rv1, e_v1);
    chk({tag, ":rerr1"}, rerr1, e_e1);
    chk({tag, ":wc1"}, wc1, m_wc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_bm[i]  = 1'b0;
    end
    m_wc = 0;
    e_v0 = 0; e_e0 = 0; e_d0 = '0;
    e_v1 = 0; e_e1 = 0; e_d1 = '0;
    p_v = 0; p_e = 0; p_d = '0;
  endtask

  task automatic do_reset();
    we = 0; re = 0; clr = 0;
    rst = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input string tag, input bit w, input logic [3:0] wa,
                      input logic [7:0] d, input bit r,
                      input logic [3:0] ra, input bit c);
    logic [7:0] rd;
    bit         er;
    we = w; waddr = wa; din = d; re = r; raddr = ra; clr = c;
    @(posedge clk);
    if (w && wa == ra) begin
      rd = d; er = 0;
    end else if (c || !m_bm[ra]) begin
      rd = '0; er = 1;
    end else begin
      rd = m_mem[ra]; er = 0;
    end
    e_v1 = p_v;
    e_e1 = p_v ? p_e : 1'b0;
    if (p_v) e_d1 = p_d;
    p_v = r; p_d = rd; p_e = er;
    e_v0 = r;
    e_e0 = r ? er : 1'b0;
    if (r) e_d0 = rd;
    if (c) begin
      for (int i = 0; i < 16; i++) m_bm[i] = 1'b0;
    end
    if (w) begin
      m_mem[wa] = d;
      m_bm[wa]  = 1'b1;
    end
    m_wc = 0;
    for (int i = 0; i < 16; i++) m_wc += int'(m_bm[i]);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 4'd0, 8'd0, 0, 4'd0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    step("t1_rd14", 0, 0, 0, 1, 4'd14, 0);
    chk("t1_rerr", rerr0, 1);
    chk("t1_dout", dout0, 0);
    idle("t1_idle");

    step("t2_w4", 1, 4'd4, 8'd32, 0, 0, 0);
    step("t2_w3", 1, 4'd3, 8'd31, 0, 0, 0);
    step("t2_r4", 0, 0, 0, 1, 4'd4, 0);
    chk("t2_d32", dout0, 8'd32);
    step("t2_r3", 0, 0, 0, 1, 4'd3, 0);
    chk("t2_d31", dout0, 8'd31);
    chk("t2_wc", wc0, 2);
    idle("t2_idle");

    do_reset();
    for (int l = 0; l < 16; l++) step("t3_w1", 1, 4'd1, 8'(l), 0, 0, 0);
    step("t3_r1", 0, 0, 0, 1, 4'd1, 0);
    chk("t3_d15", dout0, 8'd15);
    chk("t3_wc1", wc0, 1);
    step("t3_byp", 1, 4'd7, 8'hA5, 1, 4'd7, 0);
    chk("t3_a5", dout0, 8'hA5);
    idle("t3_idle");

    do_reset();
    for (int i = 0; i < 16; i++) step("t4_w", 1, 4'(i), 8'(i), 0, 0, 0);
    for (int i = 0; i < 16; i++) step("t4_rd", 0, 0, 0, 1, 4'(i), 0);
    idle("t4_flush");
    chk("t4_last", dout1, 8'd15);
    chk("t4_wc16", wc1, 16);
    idle("t4_idle");

    step("t5_clrw", 1, 4'd5, 8'd9, 0, 0, 1);
    chk("t5_wc1", wc0, 1);
    step("t5_r5", 0, 0, 0, 1, 4'd5, 0);
    chk("t5_d9", dout0, 8'd9);
    step("t5_r6", 0, 0, 0, 1, 4'd6, 0);
    chk("t5_err6", rerr0, 1);
    step("t5_clrr", 0, 0, 0, 1, 4'd5, 1);
    step("t5_clrrw", 1, 4'd2, 8'h3C, 1, 4'd2, 1);
    idle("t5_idle");

    step("t6_w4", 1, 4'd4, 8'h44, 0, 0, 0);
    step("t6_rd", 0, 0, 0, 1, 4'd4, 0);
    #4;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("t6_midrst");
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle("t6_rel0");
    idle("t6_rel1");
    step("t6_r4", 0, 0, 0, 1, 4'd4, 0);
    chk("t6_err", rerr0, 1);
    idle("t6_idle");

    for (int k = 0; k < 300; k++) begin
      step("rand",
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
    end
    idle("rand_flush");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ram_resp16x8.md
# sync_ram_resp16x8

Synchronous 16x8 memory responder with per-location written-tracking, read-valid signalling and an optional output pipeline stage. It sits at the memory end of the existing we/re/waddr/raddr/din/dout bus and serves the controllers and benches that drive that bus. It adds three observables the plain RAM lacks:
- `rvalid` marks each returned read.
- `rerr` flags reads of never-written locations.
- `wcount` reports how many distinct locations hold data.

## Interface
Parameters:
- DW, 8, data width
- AW, 4, address width; depth = 2**AW = 16
- OUT_REG, 0, 1 adds one registered output stage (read latency 2 instead of 1)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of written-tracking
- we  in  1  write enable
- waddr  in  AW  write address
- din  in  DW  write data
- re  in  1  read enable
- raddr  in  AW  read address
- dout  out  DW  read data
- rvalid  out  1  dout/rerr valid this cycle
- rerr  out  1  read hit a never-written location
- wcount  out  AW+1  number of distinct written locations, 0..16

## Operation
- **Reset (rst=0), asynchronous:**
  - all 16 data words = 0, written bitmap = 0
  - dout = 0, rvalid = 0, rerr = 0, wcount = 0
  - the pipeline stage is flushed
  - reset mid-read discards the pending response; no rvalid pulse follows reset release.
- **Write** (we=1 at edge): mem[waddr] <= din. If bitmap[waddr]=0, set it and increment wcount. Rewriting a location does not change wcount.
- **Read** (re=1 at edge):
  - if the location is written: response dout = mem[raddr], rerr = 0.
  - if the location is unwritten: dout = 0, rerr = 1.
  - rvalid pulses for exactly one cycle per accepted read.
- **No read** (re=0): rvalid = 0 and rerr = 0; dout holds its last value.
- **Same-edge we and re, same address:** write-first. Response dout = din, rerr = 0.
- **Same-edge we and re, different addresses:** both proceed independently. The read returns old contents.
- **clr=1 at edge:** bitmap <= 0, wcount <= 0. Data words are untouched but become unreadable, since such reads return 0 with rerr=1.
  - clr + we: the written address ends marked, wcount = 1.
  - clr + re (no same-address write): rerr = 1, dout = 0.
  - clr + re + we to the same address: dout = din, rerr = 0.
- **Back-to-back reads** every cycle are supported at full throughput with no stalls.
- **Address wrap:** there are none; every 4-bit address is legal.
- **wcount width:** AW+1 bits, so 16 is representable. It cannot exceed 16.

## Timing
- **OUT_REG=0:** re sampled at edge N gives dout/rvalid/rerr valid after edge N, for cycle N..N+1. Latency 1.
- **OUT_REG=1:** the same response appears one edge later. Latency 2, still one response per cycle.
- **Write visibility:** a write at edge N is visible to a read at edge N (bypass) and to any later read.
- **wcount** updates after the write edge.
- **Response sources:**
  - rvalid/rerr/dout are registered outputs with no combinational path from inputs.
  - The bypass mux is ahead of the output register.

## Structure
- Package `ram16x8_pkg`: DW, AW, DEPTH constants and the `ram_rsp_t` struct {data, err}, which is the pipeline payload.
- Sub-module `ram16x8_store`:
  - holds the data array, written bitmap and wcount counter
  - handles write, clr and the bypass/lookup
  - presents a combinational `ram_rsp_t` for raddr
- The top `sync_ram_resp16x8` owns the re/rvalid pipeline (1 or 2 stages, selected by OUT_REG).

## Test plan
1. Reset, then read addr 14 (OUT_REG=0) -> next cycle rvalid=1, rerr=1, dout=0, wcount=0.
2. Write 32@4, then 31@3, then read 4 and read 3 -> responses 32 and 31 on consecutive cycles with rerr=0; wcount=2.
3. Write l@1 for l=0..15, then read 1 -> dout=15; wcount=1. Same-edge we=1 din=8'hA5 addr 7 with re addr 7 -> dout=A5, rerr=0.
4. Write 0..15 to addresses 0..15, then stream reads 0..15 back-to-back with OUT_REG=1 -> dout=0..15 starting 2 cycles after first re, rvalid high 16 consecutive cycles; wcount=16.
5. With all written, assert clr with we=1 addr 5 din=9 -> wcount=1; read 5 -> 9; read 6 -> rerr=1, dout=0.
6. Issue a read, drop rst low 5 ns after the edge -> rvalid, dout and wcount go 0 immediately. No rvalid after release; read 4 then returns rerr=1.
